// File: rtl/scroll_controller_if.sv
// Per-frame input/output bundle of the scroll stage: vsync, hand tracking in, world offsets out.
interface scroll_controller_if;
    logic               vsync;
    logic        [10:0] userhand1x;
    logic        [9:0]  userhand1y;
    logic        [10:0] userhand2x;
    logic        [9:0]  userhand2y;
    logic               usergrab1;
    logic               usergrab2;
    logic signed [12:0] screeny;
    logic signed [11:0] screenx;
    logic        [1:0]  grabbing;
    logic               falling;
    logic               frame_tick;

    modport master (
        output vsync, userhand1x, userhand1y, userhand2x, userhand2y, usergrab1, usergrab2,
        input  screeny, screenx, grabbing, falling, frame_tick
    );

    modport slave (
        input  vsync, userhand1x, userhand1y, userhand2x, userhand2y, usergrab1, usergrab2,
        output screeny, screenx, grabbing, falling, frame_tick
    );
endinterface

// File: rtl/scroll_controller.sv
// Once-per-frame camera stage: a grabbing hand drags the world, otherwise the climber
// falls with capped constant acceleration. All state moves only on the vsync falling edge.
module scroll_controller #(
    parameter int START_Y  = 0,
    parameter int MIN_Y    = -2400,
    parameter int MAX_Y    = 0,
    parameter int MIN_X    = -320,
    parameter int MAX_X    = 320,
    parameter int MAX_FALL = 8
) (
    input  logic               vclock,
    input  logic               reset,
    scroll_controller_if.slave bus
);
    localparam int unsigned AW  = 15;
    localparam int unsigned YW  = 13;
    localparam int unsigned XW  = 12;
    localparam int unsigned HXW = 11;
    localparam int unsigned HYW = 10;

    typedef logic signed [AW-1:0] wide_t;
    typedef enum logic [1:0] {FREE = 2'd0, HOLD1 = 2'd1, HOLD2 = 2'd2} state_t;

    localparam wide_t MIN_Y_W    = wide_t'(MIN_Y);
    localparam wide_t MAX_Y_W    = wide_t'(MAX_Y);
    localparam wide_t MIN_X_W    = wide_t'(MIN_X);
    localparam wide_t MAX_X_W    = wide_t'(MAX_X);
    localparam wide_t MAX_FALL_W = wide_t'(MAX_FALL);
    localparam wide_t ONE_W      = wide_t'(1);
    localparam wide_t ZERO_W     = wide_t'(0);

    function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        wide_t r;
        r = v;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        return r;
    endfunction

    function automatic wide_t zext_x(input logic [HXW-1:0] h);
        return wide_t'({{(AW-HXW){1'b0}}, h});
    endfunction

    function automatic wide_t zext_y(input logic [HYW-1:0] h);
        return wide_t'({{(AW-HYW){1'b0}}, h});
    endfunction

    state_t                 state_q, state_n;
    wide_t                  vel_q, vel_n;
    logic signed [YW-1:0]   screeny_q, screeny_n;
    logic signed [XW-1:0]   screenx_q, screenx_n;
    logic        [1:0]      grabbing_q, grabbing_n;
    logic                   falling_q, falling_n;
    logic                   frame_tick_q, frame_tick_n;
    logic                   vsync_d_q;
    logic        [HXW-1:0]  anchor_hx_q, anchor_hx_n;
    logic        [HYW-1:0]  anchor_hy_q, anchor_hy_n;
    logic signed [XW-1:0]   anchor_sx_q, anchor_sx_n;
    logic signed [YW-1:0]   anchor_sy_q, anchor_sy_n;

    logic                   tick_c;
    logic        [HXW-1:0]  sel_hx;
    logic        [HYW-1:0]  sel_hy;
    wide_t                  drag_y, drag_x, vel_inc, vel_cap, fall_y;

    // Datapath: all arithmetic at 15 bits so nothing wraps before the clamp.
    always_comb begin
        tick_c  = vsync_d_q & ~bus.vsync;
        sel_hx  = (state_q == HOLD2) ? bus.userhand2x : bus.userhand1x;
        sel_hy  = (state_q == HOLD2) ? bus.userhand2y : bus.userhand1y;
        drag_y  = clamp(wide_t'(anchor_sy_q) - (zext_y(sel_hy) - zext_y(anchor_hy_q)),
                        MIN_Y_W, MAX_Y_W);
        drag_x  = clamp(wide_t'(anchor_sx_q) - (zext_x(sel_hx) - zext_x(anchor_hx_q)),
                        MIN_X_W, MAX_X_W);
        vel_inc = vel_q + ONE_W;
        vel_cap = (vel_inc > MAX_FALL_W) ? MAX_FALL_W : vel_inc;
        fall_y  = clamp(wide_t'(screeny_q) + vel_cap, MIN_Y_W, MAX_Y_W);
    end

    // Next-state and next-output logic; everything holds unless this is a tick cycle.
    always_comb begin
        state_n      = state_q;
        vel_n        = vel_q;
        screeny_n    = screeny_q;
        screenx_n    = screenx_q;
        grabbing_n   = grabbing_q;
        falling_n    = falling_q;
        frame_tick_n = tick_c;
        anchor_hx_n  = anchor_hx_q;
        anchor_hy_n  = anchor_hy_q;
        anchor_sx_n  = anchor_sx_q;
        anchor_sy_n  = anchor_sy_q;

        if (tick_c) begin
            case (state_q)
                FREE: begin
                    if (bus.usergrab1) begin
                        state_n = HOLD1;
                    end else if (bus.usergrab2) begin
                        state_n = HOLD2;
                    end else begin
                        screeny_n = YW'(fall_y);
                        vel_n     = (fall_y == MAX_Y_W) ? ZERO_W : vel_cap;
                    end
                end
                HOLD1: begin
                    if (bus.usergrab1) begin
                        screeny_n = YW'(drag_y);
                        screenx_n = XW'(drag_x);
                    end else if (bus.usergrab2) begin
                        state_n = HOLD2;
                    end else begin
                        state_n = FREE;
                    end
                end
                HOLD2: begin
                    if (bus.usergrab2) begin
                        screeny_n = YW'(drag_y);
                        screenx_n = XW'(drag_x);
                    end else if (bus.usergrab1) begin
                        state_n = HOLD1;
                    end else begin
                        state_n = FREE;
                    end
                end
                default: state_n = FREE;
            endcase

            // Any entry into a hold (including hand-to-hand) re-anchors at the current offsets.
            if (state_n != state_q && state_n != FREE) begin
                anchor_hx_n = (state_n == HOLD2) ? bus.userhand2x : bus.userhand1x;
                anchor_hy_n = (state_n == HOLD2) ? bus.userhand2y : bus.userhand1y;
                anchor_sx_n = screenx_q;
                anchor_sy_n = screeny_q;
                vel_n       = ZERO_W;
            end

            grabbing_n = {state_n == HOLD2, state_n == HOLD1};
            falling_n  = (state_n == FREE) && (wide_t'(screeny_n) < MAX_Y_W);
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            state_q      <= FREE;
            vel_q        <= ZERO_W;
            screeny_q    <= YW'(START_Y);
            screenx_q    <= '0;
            grabbing_q   <= 2'b00;
            falling_q    <= (START_Y < MAX_Y);
            frame_tick_q <= 1'b0;
            vsync_d_q    <= 1'b1;
            anchor_hx_q  <= '0;
            anchor_hy_q  <= '0;
            anchor_sx_q  <= '0;
            anchor_sy_q  <= '0;
        end else begin
            state_q      <= state_n;
            vel_q        <= vel_n;
            screeny_q    <= screeny_n;
            screenx_q    <= screenx_n;
            grabbing_q   <= grabbing_n;
            falling_q    <= falling_n;
            frame_tick_q <= frame_tick_n;
            vsync_d_q    <= bus.vsync;
            anchor_hx_q  <= anchor_hx_n;
            anchor_hy_q  <= anchor_hy_n;
            anchor_sx_q  <= anchor_sx_n;
            anchor_sy_q  <= anchor_sy_n;
        end
    end

    assign bus.screeny    = screeny_q;
    assign bus.screenx    = screenx_q;
    assign bus.grabbing   = grabbing_q;
    assign bus.falling    = falling_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench for scroll_controller: frames push hand-computed expectations,
// a monitor pops one per frame_tick and compares.
module tb_scroll_controller;
    logic vclock = 1'b0;
    logic rst0;
    logic rst1;

    scroll_controller_if bus0();
    scroll_controller_if bus1();

    scroll_controller dut0 (.vclock(vclock), .reset(rst0), .bus(bus0));
    scroll_controller #(.START_Y(-100)) dut1 (.vclock(vclock), .reset(rst1), .bus(bus1));

    always #5 vclock = ~vclock;

    typedef struct {
        logic signed [12:0] y;
        logic signed [11:0] x;
        logic        [1:0]  g;
        logic               f;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   tick_no = 0;
    int   idle_pulses = 0;

    // Monitor: every frame_tick must match the oldest outstanding expectation.
    always @(negedge vclock) begin
        if (bus1.frame_tick === 1'b1) begin
            tick_no++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick%0d unexpected frame_tick y=%0d x=%0d", tick_no, bus1.screeny, bus1.screenx);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus1.screeny !== mon_e.y || bus1.screenx !== mon_e.x ||
                    bus1.grabbing !== mon_e.g || bus1.falling !== mon_e.f) begin
                    errors++;
                    $display("FAIL tick%0d actual y=%0d x=%0d g=%b f=%b required y=%0d x=%0d g=%b f=%b",
                             tick_no, bus1.screeny, bus1.screenx, bus1.grabbing, bus1.falling,
                             mon_e.y, mon_e.x, mon_e.g, mon_e.f);
                end
            end
        end
        if (bus0.frame_tick === 1'b1) idle_pulses++;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One video frame: present inputs, drop vsync for 3 cycles (must tick once), then scramble inputs.
    task automatic frame(input logic g1, input logic g2, input int h1x, input int h1y,
                         input int h2x, input int h2y, input int ey, input int ex,
                         input logic [1:0] eg, input logic ef);
        exp_t e;
        e.y = 13'(ey);
        e.x = 12'(ex);
        e.g = eg;
        e.f = ef;
        exp_q.push_back(e);
        @(negedge vclock);
        bus1.usergrab1  = g1;
        bus1.usergrab2  = g2;
        bus1.userhand1x = 11'(h1x);
        bus1.userhand1y = 10'(h1y);
        bus1.userhand2x = 11'(h2x);
        bus1.userhand2y = 10'(h2y);
        bus1.vsync      = 1'b0;
        repeat (3) @(negedge vclock);
        bus1.vsync      = 1'b1;
        bus1.usergrab1  = 1'($urandom);
        bus1.usergrab2  = 1'($urandom);
        bus1.userhand1x = 11'($urandom);
        bus1.userhand1y = 10'($urandom);
        bus1.userhand2x = 11'($urandom);
        bus1.userhand2y = 10'($urandom);
        repeat (3) @(negedge vclock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int fall_y[20] = '{-99, -97, -94, -90, -85, -79, -72, -64, -56, -48,
                           -40, -32, -24, -16, -8, 0, 0, 0, 0, 0};

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.vsync = 1'b1; bus0.usergrab1 = 1'b0; bus0.usergrab2 = 1'b0;
        bus0.userhand1x = '0; bus0.userhand1y = '0; bus0.userhand2x = '0; bus0.userhand2y = '0;
        bus1.vsync = 1'b1; bus1.usergrab1 = 1'b0; bus1.usergrab2 = 1'b0;
        bus1.userhand1x = '0; bus1.userhand1y = '0; bus1.userhand2x = '0; bus1.userhand2y = '0;
        repeat (2) @(negedge vclock);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge vclock);

        // Reset values, default and START_Y=-100 instances
        chk("rst0_screeny", int'(bus0.screeny), 0);
        chk("rst0_screenx", int'(bus0.screenx), 0);
        chk("rst0_grabbing", int'(bus0.grabbing), 0);
        chk("rst0_falling", int'(bus0.falling), 0);
        chk("rst1_screeny", int'(bus1.screeny), -100);
        chk("rst1_falling", int'(bus1.falling), 1);
        chk("rst1_frame_tick", int'(bus1.frame_tick), 0);

        // Fall and land
        for (int i = 0; i < 20; i++)
            frame(1'b0, 1'b0, 0, 0, 0, 0, fall_y[i], 0, 2'b00, logic'(fall_y[i] < 0));

        // Drag down to -500 then release
        frame(1'b1, 1'b0, 100, 0,   0, 0,   0, 0, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 100, 500, 0, 0, -500, 0, 2'b01, 1'b0);
        frame(1'b0, 1'b0, 0, 0,     0, 0, -500, 0, 2'b00, 1'b1);
        // Drag example
        frame(1'b1, 1'b0, 400, 200, 0, 0, -500, 0,  2'b01, 1'b0);
        frame(1'b1, 1'b0, 380, 260, 0, 0, -560, 20, 2'b01, 1'b0);
        frame(1'b0, 1'b0, 0, 0,     0, 0, -560, 20, 2'b00, 1'b1);
        // Simultaneous grab, hand switch, drag with hand 2, release
        frame(1'b1, 1'b1, 380, 260, 500, 300, -560, 20, 2'b01, 1'b0);
        frame(1'b0, 1'b1, 0, 0,     500, 300, -560, 20, 2'b10, 1'b0);
        frame(1'b0, 1'b1, 0, 0,     490, 310, -570, 30, 2'b10, 1'b0);
        frame(1'b0, 1'b0, 0, 0,     0, 0,     -570, 30, 2'b00, 1'b1);
        // Climb towards the top and clamp
        frame(1'b1, 1'b0, 500, 30,   0, 0,  -570, 30, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 500, 1000, 0, 0, -1540, 30, 2'b01, 1'b0);
        frame(1'b0, 1'b0, 0, 0,      0, 0, -1540, 30, 2'b00, 1'b1);
        frame(1'b1, 1'b0, 500, 30,   0, 0, -1540, 30, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 500, 880,  0, 0, -2390, 30, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 500, 930,  0, 0, -2400, 30, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 130, 930,  0, 0, -2400, 320, 2'b01, 1'b0);
        frame(1'b1, 1'b0, 1200, 930, 0, 0, -2400, -320, 2'b01, 1'b0);
        frame(1'b1, 1'b1, 1200, 930, 0, 0, -2400, -320, 2'b01, 1'b0);
        frame(1'b0, 1'b0, 0, 0,      0, 0, -2400, -320, 2'b00, 1'b1);
        // Hand 2 hold down to -800
        frame(1'b0, 1'b1, 0, 0, 600, 1000, -2400, -320, 2'b10, 1'b0);
        frame(1'b0, 1'b1, 0, 0, 600, 0,    -1400, -320, 2'b10, 1'b0);
        frame(1'b0, 1'b0, 0, 0, 0, 0,      -1400, -320, 2'b00, 1'b1);
        frame(1'b0, 1'b1, 0, 0, 600, 1000, -1400, -320, 2'b10, 1'b0);
        frame(1'b0, 1'b1, 0, 0, 600, 400,   -800, -320, 2'b10, 1'b0);

        // Reset coincident with a tick while in HOLD2
        @(negedge vclock);
        bus1.usergrab1  = 1'b0;
        bus1.usergrab2  = 1'b1;
        bus1.userhand2x = 11'd600;
        bus1.userhand2y = 10'd100;
        bus1.vsync      = 1'b0;
        rst1            = 1'b1;
        @(negedge vclock);
        chk("midrst_screeny", int'(bus1.screeny), -100);
        chk("midrst_screenx", int'(bus1.screenx), 0);
        chk("midrst_grabbing", int'(bus1.grabbing), 0);
        chk("midrst_frame_tick", int'(bus1.frame_tick), 0);
        rst1           = 1'b0;
        bus1.vsync     = 1'b1;
        bus1.usergrab2 = 1'b0;
        repeat (2) @(negedge vclock);
        frame(1'b0, 1'b0, 0, 0, 0, 0, -99, 0, 2'b00, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge vclock);
        chk("queue_drained", exp_q.size(), 0);
        chk("tick_count", tick_no, 46);

        // Idle instance saw no vsync edges throughout
        chk("idle_frame_tick_pulses", idle_pulses, 0);
        chk("idle_screeny", int'(bus0.screeny), 0);
        chk("idle_grabbing", int'(bus0.grabbing), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
